// File: rtl/cnt_resp_checker.sv
// rtl/cnt_resp_checker.sv - response checker that predicts an up/down counter and flags mismatches
module cnt_resp_checker #(
    parameter int WIDTH     = 2,
    parameter int ERR_CNT_W = 8,
    parameter int ERR_MAX   = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 arm,
    input  logic                 en,
    input  logic                 up1_dn0,
    input  logic                 cin,
    input  logic [WIDTH-1:0]     cnt_in,
    input  logic                 co_in,
    input  logic                 clr_err,
    output logic                 tracking,
    output logic                 err,
    output logic                 fault,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_FAULT} state_t;

    localparam logic [WIDTH-1:0]     CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0]     CNT_ALL = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_ALL = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_LIM = ERR_CNT_W'(ERR_MAX);

    state_t               r_state;
    logic [WIDTH-1:0]     r_exp;
    logic                 r_tracking;
    logic                 r_err;
    logic                 r_fault;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_step;
    logic [WIDTH-1:0]     w_nxt_obs;
    logic [WIDTH-1:0]     w_nxt_exp;
    logic                 w_co_exp;
    logic                 w_mism;
    logic [ERR_CNT_W-1:0] w_cnt_base;
    logic [ERR_CNT_W-1:0] w_cnt_inc;

    assign w_step    = en & cin;
    assign w_nxt_obs = !w_step ? cnt_in : (up1_dn0 ? cnt_in + CNT_ONE : cnt_in - CNT_ONE);
    assign w_nxt_exp = !w_step ? r_exp  : (up1_dn0 ? r_exp + CNT_ONE  : r_exp - CNT_ONE);
    // Carry-out belongs to the value currently on cnt_in, so it is judged against r_exp now.
    assign w_co_exp  = w_step & (up1_dn0 ? (r_exp == CNT_ALL) : (r_exp == '0));
    assign w_mism    = (cnt_in != r_exp) | (co_in != w_co_exp);

    // A same-edge clear is applied before the mismatch is counted.
    assign w_cnt_base = clr_err ? '0 : r_err_cnt;
    assign w_cnt_inc  = (w_cnt_base == ERR_ALL) ? w_cnt_base : w_cnt_base + ERR_ONE;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_exp      <= '0;
            r_tracking <= 1'b0;
            r_err      <= 1'b0;
            r_fault    <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr_err) r_err_cnt <= '0;
                    if (arm) begin
                        r_state    <= S_TRACK;
                        r_tracking <= 1'b1;
                        r_exp      <= w_nxt_obs;
                    end
                end
                S_TRACK: begin
                    if (!arm) begin
                        r_state    <= S_IDLE;
                        r_tracking <= 1'b0;
                        if (clr_err) r_err_cnt <= '0;
                    end else if (w_mism) begin
                        r_err     <= 1'b1;
                        r_err_cnt <= w_cnt_inc;
                        r_exp     <= w_nxt_obs;
                        if (w_cnt_inc >= ERR_LIM) begin
                            r_state    <= S_FAULT;
                            r_tracking <= 1'b0;
                            r_fault    <= 1'b1;
                        end
                    end else begin
                        r_err_cnt <= w_cnt_base;
                        r_exp     <= w_nxt_exp;
                    end
                end
                S_FAULT: begin
                    if (clr_err) begin
                        r_state   <= S_IDLE;
                        r_fault   <= 1'b0;
                        r_err_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tracking <= 1'b0;
                    r_fault    <= 1'b0;
                end
            endcase
        end
    end

    assign tracking = r_tracking;
    assign err      = r_err;
    assign fault    = r_fault;
    assign err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_cnt_resp_checker.sv
// tb/tb_cnt_resp_checker.sv - vector table, corner sequences and random run against a reference model
module tb_cnt_resp_checker;
    localparam int WIDTH   = 2;
    localparam int MOD     = 1 << WIDTH;
    localparam int ERR_MAX = 4;
    localparam int NVEC    = 32;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       arm = 1'b0, en = 1'b0, up1_dn0 = 1'b1, cin = 1'b0, co_in = 1'b0, clr_err = 1'b0;
    logic [1:0] cnt_in = '0;
    logic       tracking, err, fault;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    cnt_resp_checker #(.WIDTH(WIDTH), .ERR_CNT_W(8), .ERR_MAX(ERR_MAX)) dut (
        .clk(clk), .n_rst(n_rst), .arm(arm), .en(en), .up1_dn0(up1_dn0), .cin(cin),
        .cnt_in(cnt_in), .co_in(co_in), .clr_err(clr_err),
        .tracking(tracking), .err(err), .fault(fault), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] in_bits;   // arm en up cin | cnt[1:0] | co clr
        logic [2:0] out_bits;  // tracking err fault
        logic [7:0] ec;
    } vec_t;

    vec_t tv [NVEC];

    // Reference model state
    bit m_active, m_fault, m_err;
    int m_exp, m_ecnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    task automatic chk_all(input string nm, input bit t, input bit e, input bit f, input int ec);
        chk({nm, ".tracking"}, 32'(tracking), 32'(t));
        chk({nm, ".err"},      32'(err),      32'(e));
        chk({nm, ".fault"},    32'(fault),    32'(f));
        chk({nm, ".err_cnt"},  32'(err_cnt),  32'(ec));
    endtask

    function automatic vec_t mk(input logic [7:0] ib, input logic [2:0] ob, input int ec);
        vec_t v;
        v.in_bits  = ib;
        v.out_bits = ob;
        v.ec       = 8'(ec);
        return v;
    endfunction

    function automatic int nxt(input int x, input bit step, input bit up);
        if (!step) return x;
        return up ? (x + 1) % MOD : (x + MOD - 1) % MOD;
    endfunction

    task automatic model_reset();
        m_active = 0; m_fault = 0; m_err = 0; m_exp = 0; m_ecnt = 0;
    endtask

    task automatic model_step();
        bit step, co_exp, mism;
        int base;
        step = en && cin;
        m_err = 0;
        if (m_fault) begin
            if (clr_err) begin m_fault = 0; m_ecnt = 0; end
        end else if (!m_active) begin
            if (clr_err) m_ecnt = 0;
            if (arm) begin m_active = 1; m_exp = nxt(int'(cnt_in), step, up1_dn0); end
        end else if (!arm) begin
            m_active = 0;
            if (clr_err) m_ecnt = 0;
        end else begin
            co_exp = step && (up1_dn0 ? (m_exp == MOD - 1) : (m_exp == 0));
            mism   = (int'(cnt_in) != m_exp) || (co_in != co_exp);
            base   = clr_err ? 0 : m_ecnt;
            m_ecnt = mism ? ((base + 1 > 255) ? 255 : base + 1) : base;
            m_err  = mism;
            m_exp  = mism ? nxt(int'(cnt_in), step, up1_dn0) : nxt(m_exp, step, up1_dn0);
            if (mism && m_ecnt >= ERR_MAX) begin m_active = 0; m_fault = 1; end
        end
    endtask

    task automatic drive(input logic [7:0] ib);
        {arm, en, up1_dn0, cin} = ib[7:4];
        cnt_in  = ib[3:2];
        co_in   = ib[1];
        clr_err = ib[0];
    endtask

    initial begin
        // arm en up cin _ cnt _ co clr  ->  tracking err fault, err_cnt
        tv[0]  = mk(8'b1111_00_00, 3'b100, 0);
        tv[1]  = mk(8'b1111_01_00, 3'b100, 0);
        tv[2]  = mk(8'b1111_10_00, 3'b100, 0);
        tv[3]  = mk(8'b1111_11_10, 3'b100, 0);
        tv[4]  = mk(8'b1111_00_00, 3'b100, 0);
        tv[5]  = mk(8'b1101_01_00, 3'b100, 0);
        tv[6]  = mk(8'b1101_00_10, 3'b100, 0);
        tv[7]  = mk(8'b1101_11_00, 3'b100, 0);
        tv[8]  = mk(8'b1101_10_00, 3'b100, 0);
        tv[9]  = mk(8'b1101_01_00, 3'b100, 0);
        tv[10] = mk(8'b1101_00_00, 3'b110, 1);
        tv[11] = mk(8'b1101_11_00, 3'b100, 1);
        tv[12] = mk(8'b1101_10_01, 3'b100, 0);
        tv[13] = mk(8'b1111_10_00, 3'b110, 1);
        tv[14] = mk(8'b1111_11_10, 3'b100, 1);
        tv[15] = mk(8'b1111_00_00, 3'b100, 1);
        tv[16] = mk(8'b1111_01_00, 3'b100, 1);
        tv[17] = mk(8'b1011_10_00, 3'b100, 1);
        tv[18] = mk(8'b1110_10_00, 3'b100, 1);
        tv[19] = mk(8'b1101_10_00, 3'b100, 1);
        tv[20] = mk(8'b1101_01_00, 3'b100, 1);
        tv[21] = mk(8'b1101_00_11, 3'b100, 0);
        tv[22] = mk(8'b1101_00_00, 3'b110, 1);
        tv[23] = mk(8'b1101_00_00, 3'b110, 2);
        tv[24] = mk(8'b1101_00_00, 3'b110, 3);
        tv[25] = mk(8'b1101_00_00, 3'b011, 4);
        tv[26] = mk(8'b1101_00_00, 3'b001, 4);
        tv[27] = mk(8'b1101_00_01, 3'b000, 0);
        tv[28] = mk(8'b0101_00_00, 3'b000, 0);
        tv[29] = mk(8'b1111_01_00, 3'b100, 0);
        tv[30] = mk(8'b1111_11_00, 3'b110, 1);
        tv[31] = mk(8'b0111_00_00, 3'b000, 1);

        #12;
        chk_all("reset", 0, 0, 0, 0);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk_all("idle_after_reset", 0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tv[i].in_bits);
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), tv[i].out_bits[2], tv[i].out_bits[1],
                    tv[i].out_bits[0], int'(tv[i].ec));
        end

        // Asynchronous reset mid-TRACK, then a clean re-arm
        drive(8'b1111_00_00);
        @(posedge clk); #1;
        drive(8'b1111_10_00);
        @(posedge clk); #1;
        chk_all("pre_abort", 1, 1, 0, 2);
        #2 n_rst = 1'b0;
        #1 chk_all("async_abort", 0, 0, 0, 0);
        drive(8'b1111_00_00);
        #2 n_rst = 1'b1;
        @(posedge clk); #1;
        chk_all("rearm", 1, 0, 0, 0);
        drive(8'b1111_01_00);
        @(posedge clk); #1;
        chk_all("rearm_next", 1, 0, 0, 0);

        // Randomised run against the reference model, resynchronised from reset
        n_rst = 1'b0;
        #2 n_rst = 1'b1;
        model_reset();
        up1_dn0 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            bit co_exp_now;
            arm = ($urandom_range(15) != 0);
            en  = ($urandom_range(3) != 0);
            cin = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) up1_dn0 = ~up1_dn0;
            clr_err = ($urandom_range(31) == 0);
            cnt_in  = (m_active && $urandom_range(7) != 0) ? 2'(m_exp) : 2'($urandom_range(MOD - 1));
            co_exp_now = en && cin && (up1_dn0 ? (m_exp == MOD - 1) : (m_exp == 0));
            co_in   = ($urandom_range(7) != 0) ? co_exp_now : 1'($urandom_range(1));
            @(posedge clk); #1;
            model_step();
            chk_all($sformatf("rand%0d", c), m_active, m_err, m_fault, m_ecnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
